// File: rtl/fetch_unit_pkg.sv
// Shared constants for the RV32I fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          TAG_W_DEFAULT    = 4;

    // addi x0,x0,0 -- harmless filler word for idle memory data lines.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are reserved at grant, filled at response, popped at head.
// Latency: a fill is visible at the head output the cycle after the fill edge.
// Backpressure: caller must not reserve when occupancy == DEPTH; pop only takes a filled head.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   flush                 drop every slot and rewind all pointers (wins over everything else)
//   reserve/_npc/_tag     claim the tail slot; npc is the fetch address + 4
//   fill/fill_instr       write data into the oldest reserved-but-unfilled slot
//   pop                   retire the head slot (ignored unless head is filled)
//   occupancy             reserved + filled slots
//   pending               reserved but not yet filled slots
//   head_*                fields of the head slot
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     reserve,
    input  logic [31:0]              reserve_npc,
    input  logic [TAG_W-1:0]         reserve_tag,
    input  logic                     fill,
    input  logic [31:0]              fill_instr,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     head_filled,
    output logic [31:0]              head_instr,
    output logic [31:0]              head_npc,
    output logic [TAG_W-1:0]         head_tag
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] filled_q;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      npc_q   [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];

    // Three pointers walk the ring in order: head <= fill <= tail.
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] occ_q;
    logic [CW-1:0] pend_q;

    logic fill_en;
    logic pop_en;

    assign fill_en = fill & (pend_q != '0);
    assign pop_en  = pop & filled_q[head_ptr];

    // Reserve, fill and pop never target the same slot in one edge: fill needs a
    // pending slot (so fill_ptr != tail), pop needs a filled head (so head != fill),
    // and reserve is blocked when full (so tail != head whenever occupancy > 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            occ_q    <= '0;
            pend_q   <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                npc_q[i]   <= '0;
                tag_q[i]   <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            occ_q    <= '0;
            pend_q   <= '0;
            filled_q <= '0;
        end else begin
            if (reserve) begin
                npc_q[tail_ptr]    <= reserve_npc;
                tag_q[tail_ptr]    <= reserve_tag;
                filled_q[tail_ptr] <= 1'b0;
                tail_ptr           <= tail_ptr + 1'b1;
            end
            if (fill_en) begin
                instr_q[fill_ptr]  <= fill_instr;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            // Clearing on pop matters: once the ring empties, head == tail may land
            // on a slot that last held a popped entry.
            if (pop_en) begin
                filled_q[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + 1'b1;
            end
            occ_q  <= occ_q + CW'(reserve) - CW'(pop_en);
            pend_q <= pend_q + CW'(reserve) - CW'(fill_en);
        end
    end

    assign occupancy   = occ_q;
    assign pending     = pend_q;
    assign head_filled = filled_q[head_ptr];
    assign head_instr  = instr_q[head_ptr];
    assign head_npc    = npc_q[head_ptr];
    assign head_tag    = tag_q[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: sequential PC generation, imem request/grant, in-order buffering.
// Latency: grant N, response M (>= N+1), instruction valid to decoder in M+1.
// Backpressure: request drops when DEPTH slots are reserved/filled; decoder stalls via i_ready.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   o_imem_req/o_imem_addr        fetch request, word aligned
//   i_imem_gnt                    request accepted this cycle
//   i_imem_rvalid/i_imem_rdata    in-order response
//   i_redirect/i_redirect_pc      flush and restart fetch
//   o_valid/i_ready               decoder handshake on the queue head
//   o_instr/o_next_pc/o_tag       head instruction, its address + 4, sequence tag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TAG_W    = TAG_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_redirect,
    input  logic [31:0]      i_redirect_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic [31:0]      o_next_pc,
    output logic [TAG_W-1:0] o_tag
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]      pc_q;
    logic [TAG_W-1:0] tag_q;
    // Responses still owed by memory for requests issued before a redirect.
    logic [CW-1:0]    drop_q;

    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    pending;
    logic             head_filled;
    logic             grant;
    logic             fill;
    logic             pop;

    // Gated on occupancy at the start of the cycle only, so a same-cycle pop
    // never feeds back into the request.
    assign o_imem_req  = ~i_rst & ~i_redirect & (occupancy < CW'(DEPTH));
    assign o_imem_addr = pc_q;

    assign grant = o_imem_req & i_imem_gnt;
    assign fill  = i_imem_rvalid & (drop_q == '0) & ~i_redirect;
    // The decoder throws away whatever it takes during a redirect, so the pop is ignored.
    assign pop   = head_filled & i_ready & ~i_redirect;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q   <= RESET_PC;
            tag_q  <= '0;
            drop_q <= '0;
        end else begin
            if (i_redirect) begin
                pc_q <= i_redirect_pc & ~32'h3;
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end

            // The tag keeps counting across redirects so stale and new streams differ.
            if (grant) begin
                tag_q <= tag_q + 1'b1;
            end

            // Every in-flight request becomes a drop on redirect; a response arriving in
            // that same cycle settles one of them (either a pending slot or an old drop).
            if (i_redirect) begin
                drop_q <= pending + drop_q - CW'(i_imem_rvalid);
            end else if (i_imem_rvalid && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_queue (
        .clk         (i_clk),
        .rst         (i_rst),
        .flush       (i_redirect),
        .reserve     (grant),
        .reserve_npc (pc_q + 32'd4),
        .reserve_tag (tag_q),
        .fill        (fill),
        .fill_instr  (i_imem_rdata),
        .pop         (pop),
        .occupancy   (occupancy),
        .pending     (pending),
        .head_filled (head_filled),
        .head_instr  (o_instr),
        .head_npc    (o_next_pc),
        .head_tag    (o_tag)
    );

    assign o_valid = head_filled;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable response latency plus a scoreboard
// of expected decoder-side entries, pushed at grant and popped at each decoder handshake.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_next_pc;
    logic [3:0]  o_tag;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC),
        .TAG_W    (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_next_pc     (o_next_pc),
        .o_tag         (o_tag)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [3:0]  out_tags[$];
    logic [31:0] out_npcs[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic        gnt_en   = 1'b1;
    logic [31:0] pc_m;
    logic [3:0]  tag_m;
    int          grants;
    int          first_gnt;
    int          first_vld;
    logic        last_req;
    logic [31:0] last_addr;

    // Memory contents: distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[17:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory, sample at negedge, update models, advance.
    task automatic step();
        exp_t e;
        i_imem_gnt = gnt_en;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = NOP_INSTR;
        end
        @(negedge clk);
        last_req  = o_imem_req;
        last_addr = o_imem_addr;
        if (o_imem_req && i_imem_gnt) begin
            check("imem_addr", o_imem_addr, pc_m);
            mq_addr.push_back(o_imem_addr);
            mq_due.push_back(cyc + lat);
            e.instr = mem_word(pc_m);
            e.npc   = pc_m + 32'd4;
            e.tag   = tag_m;
            sb.push_back(e);
            pc_m  = pc_m + 32'd4;
            tag_m = tag_m + 4'd1;
            grants++;
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (o_valid && first_vld < 0) first_vld = cyc;
        if (o_valid && i_ready && !i_redirect) begin
            check("out_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_instr", o_instr, e.instr);
                check("out_npc", o_next_pc, e.npc);
                check("out_tag", 32'(o_tag), 32'(e.tag));
            end
            out_tags.push_back(o_tag);
            out_npcs.push_back(o_next_pc);
        end
        if (i_imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (i_redirect) begin
            sb.delete();
            pc_m = i_redirect_pc & ~32'h3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = NOP_INSTR;
        i_imem_gnt    = 1'b0;
        i_ready       = 1'b0;
        sb.delete();
        mq_addr.delete();
        mq_due.delete();
        out_tags.delete();
        out_npcs.delete();
        pc_m      = RST_PC;
        tag_m     = 4'd0;
        grants    = 0;
        first_gnt = -1;
        first_vld = -1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = NOP_INSTR;
        i_ready       = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_npc", o_next_pc, 32'd0);
        check("rst_tag", 32'(o_tag), 32'd0);

        // Streaming with single-cycle memory.
        do_reset();
        lat = 1; gnt_en = 1'b1; i_ready = 1'b1;
        repeat (12) step();
        check("first_latency", 32'(first_vld - first_gnt), 32'd2);
        check("stream_first_npc", out_npcs[0], 32'h4);
        check("stream_first_tag", 32'(out_tags[0]), 32'd0);
        check("stream_third_npc", out_npcs[2], 32'hC);

        // Decoder stall fills the queue, then drains in order.
        do_reset();
        lat = 1; gnt_en = 1'b1; i_ready = 1'b0;
        repeat (10) step();
        check("stall_grants", 32'(grants), 32'd4);
        check("stall_req_low", 32'(last_req), 32'd0);
        i_ready = 1'b1;
        repeat (12) step();
        check("stall_pops", 32'(out_tags.size() >= 4), 32'd1);
        if (out_tags.size() >= 4)
            for (int i = 0; i < 4; i++) check("stall_tag", 32'(out_tags[i]), 32'(i));

        // Redirect with two fetches outstanding.
        do_reset();
        lat = 3; gnt_en = 1'b1; i_ready = 1'b1;
        repeat (2) step();
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0103;
        step();
        i_redirect = 1'b0;
        step();
        check("redir_addr", last_addr, 32'h0000_0100);
        repeat (12) step();
        check("redir_outputs", 32'(out_npcs.size() != 0), 32'd1);
        if (out_npcs.size() != 0) check("redir_first_npc", out_npcs[0], 32'h0000_0104);

        // Redirect coinciding with a stale response, followed by a second redirect.
        do_reset();
        lat = 3; gnt_en = 1'b1; i_ready = 1'b1;
        repeat (3) step();
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
        step();
        i_redirect_pc = 32'h0000_0302;
        step();
        i_redirect = 1'b0;
        repeat (15) step();
        check("b2b_outputs", 32'(out_npcs.size() != 0), 32'd1);
        if (out_npcs.size() != 0) check("b2b_first_npc", out_npcs[0], 32'h0000_0304);

        // Tag wrap and address wrap.
        do_reset();
        lat = 1; gnt_en = 1'b1; i_ready = 1'b1;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF0;
        step();
        i_redirect = 1'b0;
        repeat (26) step();
        check("wrap_count", 32'(out_tags.size() >= 20), 32'd1);
        if (out_tags.size() >= 20) begin
            for (int i = 0; i < 20; i++) check("wrap_tag", 32'(out_tags[i]), 32'(i % 16));
            check("wrap_npc_fffc", out_npcs[3], 32'h0000_0000);
            check("wrap_npc_0", out_npcs[4], 32'h0000_0004);
        end

        // Asynchronous reset with the queue partly full.
        do_reset();
        lat = 2; gnt_en = 1'b1; i_ready = 1'b0;
        repeat (3) step();
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_req", 32'(o_imem_req), 32'd0);
        do_reset();
        lat = 1; gnt_en = 1'b1; i_ready = 1'b1;
        step();
        check("rst_restart_addr", last_addr, RST_PC);
        repeat (8) step();
        check("rst_restart_out", 32'(out_tags.size() != 0), 32'd1);
        if (out_tags.size() != 0) check("rst_restart_tag", 32'(out_tags[0]), 32'd0);

        // Drain: everything granted must reach the decoder.
        gnt_en = 1'b0;
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
